otf_sd_converter: RTL and testbench

- Downstream of the online (MSDF) radix-2 multiplier.
- Consumes the multiplier's serial signed-digit product stream, one digit per cycle, most significant first.
- Uses on-the-fly conversion (Q/QM register pair) to build a PREC-digit fraction in two's complement, with no carry-propagate adder.
- Presents each completed word through a valid/ready output register, for capture by the result store and the bench.

---
 rtl/otf_sd_converter.sv | 153 +++++++++++++++
 tb/tb_otf_sd_converter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otf_sd_converter.sv
// otf_sd_converter: on-the-fly conversion of an MSDF radix-2 signed-digit stream
// (most significant digit first) into a PREC-digit two's complement fraction.
// The Q/QM register pair avoids any carry-propagate adder.
//
// Optional build macro: OTF_DEBUG_EN adds the q_dis_o, qm_dis_o and last_digit_dis_o
// debug outputs. The core behaviour is the same in both builds.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start_i          first digit of a new word (sampled only with digit_valid_i)
//   digit_valid_i    digit_in_i holds a product digit this cycle
//   digit_in_i       signed digit {plus,minus}: 10=+1, 01=-1, 00=0, 11=illegal
//   result_o         sign bit plus PREC fraction bits (value = result_o / 2^PREC)
//   result_valid_o   result_o holds an unconsumed word
//   result_ready_i   consumer accepts result_o when valid and ready
//   busy_o           1..PREC-1 digits of a word accepted
//   digit_cnt_o      digits accepted in the current word
//   overrun_o        sticky: a completed word overwrote an unconsumed one
//   code_err_o       sticky: illegal digit code 11 received
module otf_sd_converter #(
  parameter int unsigned PREC  = 8,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             digit_valid_i,
  input  logic [1:0]       digit_in_i,
  output logic [PREC:0]    result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] digit_cnt_o,
  output logic             overrun_o,
  output logic             code_err_o
`ifdef OTF_DEBUG_EN
  ,
  output logic [PREC:0]    q_dis_o,
  output logic [PREC:0]    qm_dis_o,
  output logic [1:0]       last_digit_dis_o
`endif
);

  logic [PREC:0]    q_q, q_d, qm_q, qm_d;
  logic [PREC:0]    q_prev, qm_prev;
  logic [PREC:0]    result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             code_err_q, code_err_d;
  logic             in_word, complete;

  always_comb begin
    q_d        = q_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    code_err_d = code_err_q;

    // A start digit restarts from the reset pair, aborting any partial word.
    q_prev   = start_i ? '0 : q_q;
    qm_prev  = start_i ? '1 : qm_q;
    cnt_base = start_i ? '0 : cnt_q;
    cnt_inc  = cnt_base + CNT_W'(1);

    // Digits outside a word (not busy, no start) are discarded.
    in_word  = digit_valid_i && (start_i || (cnt_q != '0));
    complete = in_word && (cnt_inc == CNT_W'(PREC));

    if (digit_valid_i && (digit_in_i == 2'b11)) begin
      code_err_d = 1'b1;
    end

    if (in_word) begin
      case (digit_in_i)
        2'b10: begin
          q_d  = {q_prev[PREC-1:0], 1'b1};
          qm_d = {q_prev[PREC-1:0], 1'b0};
        end
        2'b01: begin
          q_d  = {qm_prev[PREC-1:0], 1'b1};
          qm_d = {qm_prev[PREC-1:0], 1'b0};
        end
        // 00 and the illegal 11 both convert as a zero digit.
        default: begin
          q_d  = {q_prev[PREC-1:0], 1'b0};
          qm_d = {qm_prev[PREC-1:0], 1'b1};
        end
      endcase
      cnt_d = complete ? '0 : cnt_inc;
    end

    if (valid_q && result_ready_i) begin
      valid_d = 1'b0;
    end

    // Completion wins over a same-cycle consume; only an unconsumed word is an overrun.
    if (complete) begin
      result_d = q_d;
      valid_d  = 1'b1;
      if (valid_q && !result_ready_i) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      qm_q       <= '1;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qm_q       <= qm_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      code_err_q <= code_err_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (cnt_q != '0);
  assign digit_cnt_o    = cnt_q;
  assign overrun_o      = overrun_q;
  assign code_err_o     = code_err_q;

`ifdef OTF_DEBUG_EN
  logic [1:0] last_digit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_digit_q <= 2'b00;
    end else if (digit_valid_i) begin
      last_digit_q <= digit_in_i;
    end
  end

  assign q_dis_o          = q_q;
  assign qm_dis_o         = qm_q;
  assign last_digit_dis_o = last_digit_q;
`endif

endmodule

// File: tb/tb_otf_sd_converter.sv
module tb_otf_sd_converter;
  localparam int P  = 4;
  localparam int CW = 9;

  localparam logic [1:0] PL = 2'b10;
  localparam logic [1:0] MI = 2'b01;
  localparam logic [1:0] ZE = 2'b00;
  localparam logic [1:0] IL = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          digit_valid_i;
  logic [1:0]    digit_in_i;
  logic [P:0]    result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;
  logic [CW-1:0] digit_cnt_o;
  logic          overrun_o;
  logic          code_err_o;
`ifdef OTF_DEBUG_EN
  logic [P:0]    q_dis_o;
  logic [P:0]    qm_dis_o;
  logic [1:0]    last_digit_dis_o;
`endif

  otf_sd_converter #(
    .PREC  (P),
    .CNT_W (CW)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .digit_valid_i  (digit_valid_i),
    .digit_in_i     (digit_in_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .digit_cnt_o    (digit_cnt_o),
    .overrun_o      (overrun_o),
    .code_err_o     (code_err_o)
`ifdef OTF_DEBUG_EN
    ,
    .q_dis_o          (q_dis_o),
    .qm_dis_o         (qm_dis_o),
    .last_digit_dis_o (last_digit_dis_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the word is the plain sum of digit_i * 2^(P-i).
  int         m_cnt;
  int         m_acc;
  bit         m_valid;
  bit         m_ovr;
  bit         m_cerr;
  logic [P:0] exp_q[$];
  bit         mon_en = 1'b0;

  function automatic int dval(input logic [1:0] d);
    case (d)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_acc   = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_cerr  = 1'b0;
    exp_q.delete();
  endtask

  // Applies one clock edge of the spec's rules to the model.
  task automatic model_edge(input bit s, input bit v, input logic [1:0] d, input bit r);
    bit         complete;
    int         w;
    logic [P:0] wb;
    logic [P:0] old;
    complete = 1'b0;
    w = 0;
    if (v && d == 2'b11) m_cerr = 1'b1;
    if (v && (s || m_cnt != 0)) begin
      if (s) begin
        m_cnt = 1;
        m_acc = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_acc = m_acc + dval(d) * (1 << (P - m_cnt));
      if (m_cnt == P) begin
        complete = 1'b1;
        w = m_acc;
        m_cnt = 0;
      end
    end
    if (complete) begin
      wb = w[P:0];
      if (m_valid && !r) begin
        m_ovr = 1'b1;
        old = exp_q.pop_back();
      end
      exp_q.push_back(wb);
      m_valid = 1'b1;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [1:0] d, input bit r);
    start_i        = s;
    digit_valid_i  = v;
    digit_in_i     = d;
    result_ready_i = r;
    @(posedge clk);
    model_edge(s, v, d, r);
    #1;
  endtask

  // ds holds P digits, first digit in the top two bits.
  task automatic send_word(input logic [2*P-1:0] ds, input bit r, input bit r_last);
    for (int i = 0; i < P; i++) begin
      step(i == 0, 1'b1, ds[2*P-1-2*i -: 2], (i == P - 1) ? r_last : r);
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ZE, r);
  endtask

  // Called just after a step; asserts reset between edges and checks it takes effect at once.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_result", int'(result_o), 0);
    chk("rst_result_valid", int'(result_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_digit_cnt", int'(digit_cnt_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    chk("rst_code_err", int'(code_err_o), 0);
    model_reset();
    start_i       = 1'b0;
    digit_valid_i = 1'b0;
    digit_in_i    = ZE;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [P:0] e;
    if (mon_en && rst_n) begin
      chk("result_valid", int'(result_valid_o), int'(m_valid));
      chk("busy", int'(busy_o), int'(m_cnt != 0));
      chk("digit_cnt", int'(digit_cnt_o), m_cnt);
      chk("overrun", int'(overrun_o), int'(m_ovr));
      chk("code_err", int'(code_err_o), int'(m_cerr));
      if (result_valid_o && result_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0d, expected no word", result_o);
        end else begin
          e = exp_q.pop_front();
          chk("result", int'(result_o), int'(e));
        end
      end
    end
  end

  initial begin
    int rv;
    bit s;
    bit v;
    logic [1:0] d;
    rst_n          = 1'b0;
    start_i        = 1'b0;
    digit_valid_i  = 1'b0;
    digit_in_i     = ZE;
    result_ready_i = 1'b0;
    model_reset();
    #3;
    chk("init_result_valid", int'(result_valid_o), 0);
    chk("init_digit_cnt", int'(digit_cnt_o), 0);
    chk("init_result", int'(result_o), 0);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // +7/16, -15/16, +1/16 with the consumer always ready.
    send_word({PL, ZE, MI, PL}, 1'b1, 1'b1);
    idle(1, 1'b1);
    send_word({MI, MI, MI, MI}, 1'b1, 1'b1);
    idle(1, 1'b1);
    send_word({PL, MI, MI, MI}, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Two words with the consumer stalled: second overwrites, overrun sets.
    send_word({PL, ZE, ZE, ZE}, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_word({ZE, ZE, ZE, MI}, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    do_reset();

    // Aborted partial word followed by a fresh start.
    step(1'b1, 1'b1, PL, 1'b1);
    step(1'b0, 1'b1, PL, 1'b1);
    send_word({ZE, MI, ZE, ZE}, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Illegal code counts as zero; then digits outside a word are discarded.
    send_word({IL, ZE, ZE, PL}, 1'b1, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PL, 1'b1);

    // Completion coinciding with consume of the previous word.
    send_word({PL, PL, ZE, ZE}, 1'b0, 1'b0);
    send_word({ZE, PL, ZE, ZE}, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Reset in the middle of a word.
    step(1'b1, 1'b1, PL, 1'b1);
    step(1'b0, 1'b1, MI, 1'b1);
    do_reset();

    // Randomized traffic with gaps, aborts, illegal codes and back-pressure.
    for (int i = 0; i < 600; i++) begin
      s  = (m_cnt == 0) ? ($urandom % 2 == 0) : ($urandom % 12 == 0);
      v  = ($urandom % 4 != 0);
      rv = int'($urandom % 16);
      d  = (rv < 6) ? PL : (rv < 12) ? MI : (rv < 15) ? ZE : IL;
      step(s, v, d, ($urandom % 3 != 0));
    end
    idle(4, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
